// File: rtl/pipe_pkg.sv
// Shared definitions for the ExperiarCore pipe: fetch state encoding and
// instruction constants.
package pipe_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH_REQUEST = 2'd0,
        FETCH_HOLD    = 2'd1,
        FETCH_FAULT   = 2'd2
    } fetch_state_e;

    localparam logic [XLEN-1:0] PIPE_BUBBLE_INSTRUCTION = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTRUCTION_BYTES       = 32'd4;

endpackage

// File: rtl/pipe_fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over a
// request/ready handshake and hands it to the pipe on each step.
module pipe_fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stepPipe,
    input  logic            jumpEnable,
    input  logic [XLEN-1:0] jumpAddress,
    output logic            memRequest,
    output logic [XLEN-1:0] memAddress,
    input  logic            memReady,
    input  logic [XLEN-1:0] memDataRead,
    output logic [XLEN-1:0] fetchInstruction,
    output logic            fetchStall,
    output logic [XLEN-1:0] fetchPC,
    output logic            addressMisaligned
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pending_pc_q, pending_pc_d;
    logic            drop_response_q, drop_response_d;
    logic [XLEN-1:0] buffer_q, buffer_d;
    logic [XLEN-1:0] instruction_d;
    logic            stall_d;
    logic [XLEN-1:0] fetch_pc_d;
    logic            misaligned_d;
    logic            jump_taken;
    logic            response;

    // memAddress is the PC of the fetch in flight; a redirect waits in
    // pending_pc until the outstanding response has been absorbed.
    assign memRequest = rst_n && (state_q == FETCH_REQUEST);
    assign memAddress = pc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= FETCH_REQUEST;
            pc_q              <= RESET_PC;
            pending_pc_q      <= RESET_PC;
            drop_response_q   <= 1'b0;
            buffer_q          <= PIPE_BUBBLE_INSTRUCTION;
            fetchInstruction  <= PIPE_BUBBLE_INSTRUCTION;
            fetchStall        <= 1'b1;
            fetchPC           <= '0;
            addressMisaligned <= 1'b0;
        end else begin
            state_q           <= state_d;
            pc_q              <= pc_d;
            pending_pc_q      <= pending_pc_d;
            drop_response_q   <= drop_response_d;
            buffer_q          <= buffer_d;
            fetchInstruction  <= instruction_d;
            fetchStall        <= stall_d;
            fetchPC           <= fetch_pc_d;
            addressMisaligned <= misaligned_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        pending_pc_d    = pending_pc_q;
        drop_response_d = drop_response_q;
        buffer_d        = buffer_q;
        instruction_d   = fetchInstruction;
        stall_d         = fetchStall;
        fetch_pc_d      = fetchPC;
        misaligned_d    = addressMisaligned;

        jump_taken = jumpEnable && (state_q != FETCH_FAULT);
        response   = memReady && (state_q == FETCH_REQUEST);

        if (jump_taken && (jumpAddress[1:0] != 2'b00)) begin
            state_d         = FETCH_FAULT;
            misaligned_d    = 1'b1;
            instruction_d   = PIPE_BUBBLE_INSTRUCTION;
            stall_d         = 1'b1;
            drop_response_d = 1'b0;
        end else begin
            // A jump always turns a coincident step into a bubble.
            if (stepPipe) begin
                if ((state_q == FETCH_HOLD) && !jumpEnable) begin
                    instruction_d = buffer_q;
                    fetch_pc_d    = pc_q;
                    stall_d       = 1'b0;
                    pc_d          = pc_q + INSTRUCTION_BYTES;
                    state_d       = FETCH_REQUEST;
                end else begin
                    instruction_d = PIPE_BUBBLE_INSTRUCTION;
                    stall_d       = 1'b1;
                end
            end

            if (jump_taken) begin
                if (state_q == FETCH_HOLD) begin
                    pc_d    = jumpAddress;
                    state_d = FETCH_REQUEST;
                end else if (response) begin
                    pc_d            = jumpAddress;
                    drop_response_d = 1'b0;
                end else begin
                    pending_pc_d    = jumpAddress;
                    drop_response_d = 1'b1;
                end
            end else if (response) begin
                if (drop_response_q) begin
                    pc_d            = pending_pc_q;
                    drop_response_d = 1'b0;
                end else begin
                    buffer_d = memDataRead;
                    state_d  = FETCH_HOLD;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// Randomised and directed bench for pipe_fetch_stage against a
// transaction-level model of the fetch rules.
module tb_pipe_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stepPipe;
    logic        jumpEnable;
    logic [31:0] jumpAddress;
    logic        memRequest;
    logic [31:0] memAddress;
    logic        memReady;
    logic [31:0] memDataRead;
    logic [31:0] fetchInstruction;
    logic        fetchStall;
    logic [31:0] fetchPC;
    logic        addressMisaligned;

    pipe_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stepPipe          (stepPipe),
        .jumpEnable        (jumpEnable),
        .jumpAddress       (jumpAddress),
        .memRequest        (memRequest),
        .memAddress        (memAddress),
        .memReady          (memReady),
        .memDataRead       (memDataRead),
        .fetchInstruction  (fetchInstruction),
        .fetchStall        (fetchStall),
        .fetchPC           (fetchPC),
        .addressMisaligned (addressMisaligned)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: fetch PC, one-word buffer, pending redirect, fault flag.
    logic [31:0] m_pc;
    bit          m_word_valid;
    logic [31:0] m_word;
    logic [31:0] m_redirect[$];
    bit          m_fault;
    logic [31:0] m_out_instr;
    bit          m_out_stall;
    logic [31:0] m_out_pc;
    bit          m_mis;

    // Memory responder: fixed latency when lat_mode, else random.
    bit lat_mode = 1'b1;
    int lat      = 0;
    int wait_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc         = RESET_PC;
        m_word_valid = 1'b0;
        m_word       = '0;
        m_redirect.delete();
        m_fault      = 1'b0;
        m_out_instr  = '0;
        m_out_stall  = 1'b1;
        m_out_pc     = '0;
        m_mis        = 1'b0;
    endtask

    task automatic bubble();
        m_out_instr = '0;
        m_out_stall = 1'b1;
    endtask

    task automatic model_step(input bit rst_v, input bit s, input bit j,
                              input logic [31:0] a, input bit ready_in);
        bit ready;
        if (!rst_v) begin
            model_reset();
            return;
        end
        ready = !m_fault && !m_word_valid && ready_in;
        if (m_fault) begin
            if (s) bubble();
        end else if (j && (a[1:0] != 2'b00)) begin
            m_fault      = 1'b1;
            m_mis        = 1'b1;
            m_word_valid = 1'b0;
            m_redirect.delete();
            bubble();
        end else begin
            if (s) begin
                if (!j && m_word_valid) begin
                    m_out_instr  = m_word;
                    m_out_pc     = m_pc;
                    m_out_stall  = 1'b0;
                    m_pc         = m_pc + 32'd4;
                    m_word_valid = 1'b0;
                end else begin
                    bubble();
                end
            end
            if (j) begin
                if (m_word_valid || ready) begin
                    m_word_valid = 1'b0;
                    m_redirect.delete();
                    m_pc = a;
                end else begin
                    m_redirect.delete();
                    m_redirect.push_back(a);
                end
            end else if (ready) begin
                if (m_redirect.size() != 0) begin
                    m_pc = m_redirect.pop_front();
                end else begin
                    m_word       = mem_word(m_pc);
                    m_word_valid = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        bit exp_req;
        exp_req = rst_n && !m_fault && !m_word_valid;
        check("memRequest", 32'(memRequest), 32'(exp_req));
        if (exp_req) check("memAddress", memAddress, m_pc);
        check("fetchStall", 32'(fetchStall), 32'(m_out_stall));
        check("fetchInstruction", fetchInstruction, m_out_instr);
        check("fetchPC", fetchPC, m_out_pc);
        check("addressMisaligned", 32'(addressMisaligned), 32'(m_mis));
    endtask

    // One clock: check at negedge, drive inputs, advance the model, clock.
    task automatic cycle(input bit r, input bit s, input bit j, input logic [31:0] a);
        bit rdy;
        bit req_now;
        check_outputs();
        rst_n       = r;
        stepPipe    = s;
        jumpEnable  = j;
        jumpAddress = a;
        #1;
        req_now = memRequest;
        if (req_now) rdy = lat_mode ? (wait_cnt >= lat) : ($urandom_range(0, 2) == 0);
        else         rdy = 1'($urandom_range(0, 1));
        memReady    = rdy;
        memDataRead = (req_now && rdy) ? mem_word(memAddress) : $urandom;
        model_step(r, s, j, a, rdy);
        @(posedge clk);
        if (req_now && !rdy) wait_cnt++;
        else                 wait_cnt = 0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst_n       = 1'b0;
        stepPipe    = 1'b0;
        jumpEnable  = 1'b0;
        jumpAddress = '0;
        memReady    = 1'b0;
        memDataRead = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Zero-wait memory, step every other cycle.
        do_reset();
        lat_mode = 1'b1; lat = 0;
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'(i % 2), 1'b0, 32'h0);

        // Three-cycle memory latency: steps before data give bubbles.
        lat = 3;
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'(i % 2), 1'b0, 32'h0);

        // Jump to 0x200 while the fetch of 0x104 is outstanding.
        do_reset();
        lat = 0;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        lat = 3;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'h200);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'(i % 2), 1'b0, 32'h0);

        // Jump to 0x300 together with a step while holding a word.
        lat = 0;
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h300);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'(i % 2), 1'b0, 32'h0);

        // PC wrap from 0xFFFF_FFFC to 0.
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'(i % 2), 1'b0, 32'h0);

        // Random traffic with random memory latency, jumps and resets.
        lat_mode = 1'b0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit          r, s, j;
            logic [31:0] a;
            r = ($urandom_range(0, 299) != 0);
            s = 1'($urandom_range(0, 1));
            j = ($urandom_range(0, 9) == 0);
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 49) == 0) a[1:0] = 2'($urandom_range(1, 3));
            cycle(r, s, j, a);
        end

        // Misaligned jump: sticky fault, later aligned jump ignored.
        lat_mode = 1'b1; lat = 0;
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'h202);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'(i % 2), 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'h400);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'(i % 2), 1'b0, 32'h0);
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'(i % 2), 1'b0, 32'h0);
        check_outputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
